// File: rtl/vga_csr_slave.sv
// vga_csr_slave: shares one SRAM between the display read port (csr_*) and a CPU wishbone port (wb_*), with display reads taking priority.
module vga_csr_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:1] csr_adr_i,
  input  logic        csr_stb_i,
  output logic [15:0] csr_dat_o,
  input  logic [17:1] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [17:1] sram_addr_o,
  output logic        sram_we_n_o,
  output logic [1:0]  sram_bw_n_o,
  output logic [15:0] sram_data_o,
  output logic        sram_drive_o,
  input  logic [15:0] sram_data_i
);
  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;
  typedef enum logic [1:0] {T_NONE, T_CSR, T_WB} tag_t;
  state_t state, state_nx;
  tag_t tag0, tag1, tag_nx;
  logic [15:0] cap;
  logic wb_req, wb_rd, wb_wr;
  always_comb begin
    wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_o & (state == IDLE) & ~csr_stb_i;
    wb_rd = wb_req & ~wb_we_i;
    wb_wr = wb_req & wb_we_i;
    state_nx = state == IDLE ? (wb_rd ? RD1 : IDLE) : state == RD1 ? RD2 : IDLE;
    tag_nx = csr_stb_i ? T_CSR : wb_rd ? T_WB : T_NONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tag0 <= T_NONE;
      tag1 <= T_NONE;
      cap <= '0;
      csr_dat_o <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      sram_addr_o <= '0;
      sram_we_n_o <= 1'b1;
      sram_bw_n_o <= 2'b11;
      sram_data_o <= '0;
      sram_drive_o <= 1'b0;
    end else begin
      state <= state_nx;
      tag0 <= tag_nx;
      tag1 <= tag0;
      cap <= sram_data_i;
      wb_ack_o <= wb_wr | (state == RD2);
      if (tag1 == T_CSR) csr_dat_o <= cap;
      if (tag1 == T_WB) wb_dat_o <= cap;
      if (csr_stb_i) sram_addr_o <= csr_adr_i;
      else if (wb_req) sram_addr_o <= wb_adr_i;
      sram_we_n_o <= ~wb_wr;
      sram_bw_n_o <= wb_wr ? ~wb_sel_i : (csr_stb_i | wb_rd) ? 2'b00 : 2'b11;
      sram_drive_o <= wb_wr;
      if (wb_wr) sram_data_o <= wb_dat_i;
    end
endmodule
